// File: rtl/drx_mon_ser.sv
// DRX monitor serialiser: drives one slow monitor pin with either a
// registered subsample of one selected receiver lane (LANE) or a serialised
// snapshot of a whole captured word with a frame strobe (SNAPSHOT).
module drx_mon_ser #(
  parameter int PrllRank = 64,
  parameter int LaneW    = 6,
  parameter int DivW     = 8,
  parameter int CntW     = 8
) (
  input  logic                i_clk_dig_be,
  input  logic                i_rst_dig,
  input  logic [PrllRank-1:0] i_drx,
  input  logic [1:0]          i_cfg_mode,
  input  logic [LaneW-1:0]    i_cfg_lane,
  input  logic [DivW-1:0]     i_cfg_div,
  input  logic                i_cfg_cont,
  input  logic                i_trig,
  output logic                o_drx_sample,
  output logic                o_frame,
  output logic                o_busy,
  output logic [CntW-1:0]     o_snap_cnt
);

  localparam logic [1:0] ModeLane = 2'd1;
  localparam logic [1:0] ModeSnap = 2'd2;
  localparam logic [LaneW-1:0] LastIdx = LaneW'(PrllRank - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t              r_state, w_nxt_state;
  logic [PrllRank-1:0] r_shadow, w_nxt_shadow;
  logic [DivW-1:0]     r_div, w_nxt_div;
  logic [DivW-1:0]     r_pcnt, w_nxt_pcnt;
  logic [LaneW-1:0]    r_idx, w_nxt_idx;
  logic [CntW-1:0]     r_cnt, w_nxt_cnt;
  logic                r_trig_d;
  logic                r_sample, r_frame, r_busy;
  logic                w_nxt_sample, w_nxt_frame, w_nxt_busy;
  logic                w_rise, w_capture;
  logic [LaneW-1:0]    w_lane;

  assign w_rise = i_trig & ~r_trig_d;
  assign w_lane = (32'(i_cfg_lane) < 32'(PrllRank)) ? i_cfg_lane : '0;

  // Next state, datapath and next output values; outputs are derived from
  // the next state so pin, strobe and busy all update on the same edge.
  always_comb begin
    w_nxt_state  = r_state;
    w_nxt_shadow = r_shadow;
    w_nxt_div    = r_div;
    w_nxt_pcnt   = r_pcnt;
    w_nxt_idx    = r_idx;
    w_nxt_cnt    = r_cnt;
    w_nxt_sample = 1'b0;
    w_nxt_frame  = 1'b0;
    w_nxt_busy   = 1'b0;
    w_capture    = 1'b0;
    if (i_cfg_mode == ModeSnap) begin
      case (r_state)
        ST_IDLE: begin
          if (w_rise || i_cfg_cont) w_capture = 1'b1;
        end
        ST_SHIFT: begin
          if (r_pcnt == r_div) begin
            w_nxt_pcnt = '0;
            if (r_idx == LastIdx) w_nxt_state = ST_GAP;
            else                  w_nxt_idx   = r_idx + 1'b1;
          end else begin
            w_nxt_pcnt = r_pcnt + 1'b1;
          end
        end
        ST_GAP: begin
          if (r_pcnt == r_div) begin
            w_nxt_cnt = r_cnt + 1'b1;
            if (i_cfg_cont) w_capture   = 1'b1;
            else            w_nxt_state = ST_IDLE;
          end else begin
            w_nxt_pcnt = r_pcnt + 1'b1;
          end
        end
        default: w_nxt_state = ST_IDLE;
      endcase
      if (w_capture) begin
        w_nxt_state  = ST_SHIFT;
        w_nxt_shadow = i_drx;
        w_nxt_div    = i_cfg_div;
        w_nxt_pcnt   = '0;
        w_nxt_idx    = '0;
      end
      w_nxt_frame  = (w_nxt_state == ST_SHIFT);
      w_nxt_sample = w_nxt_frame & w_nxt_shadow[w_nxt_idx];
      w_nxt_busy   = (w_nxt_state != ST_IDLE);
    end else begin
      w_nxt_state = ST_IDLE;
      if (i_cfg_mode == ModeLane) w_nxt_sample = i_drx[w_lane];
    end
  end

  // State, datapath and registered output update.
  always_ff @(posedge i_clk_dig_be or posedge i_rst_dig) begin
    if (i_rst_dig) begin
      r_state  <= ST_IDLE;
      r_shadow <= '0;
      r_div    <= '0;
      r_pcnt   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_trig_d <= 1'b0;
      r_sample <= 1'b0;
      r_frame  <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt_state;
      r_shadow <= w_nxt_shadow;
      r_div    <= w_nxt_div;
      r_pcnt   <= w_nxt_pcnt;
      r_idx    <= w_nxt_idx;
      r_cnt    <= w_nxt_cnt;
      r_trig_d <= i_trig;
      r_sample <= w_nxt_sample;
      r_frame  <= w_nxt_frame;
      r_busy   <= w_nxt_busy;
    end
  end

  assign o_drx_sample = r_sample;
  assign o_frame      = r_frame;
  assign o_busy       = r_busy;
  assign o_snap_cnt   = r_cnt;

endmodule
